mig_tx_serializer: RTL
======================

# mig_tx_serializer

Reads one stored packet segment (WORDS × 256-bit words) from the MIG-backed DDR memory and streams it out as a contiguous 8-bit byte stream with a frame-enable strobe. It is the transmit-side counterpart of the receive path, which packs 8-bit rx bytes into 256-bit words and writes them to memory. It uses the same DDR address map: addr[5:0] word index, addr[7:6] copy, addr[23:8] segment number, addr[24] = 0. Its byte output feeds the MAC/framing stage that adds preamble and CRC.

## Interface
- WORDS, 4, number of 256-bit words per segment (1..64); a frame is WORDS*32 bytes.
- clk  in  1  single clock; MIG user clock domain; all logic on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to send a segment; sampled only in IDLE.
- segnum  in  16  segment number, captured with start.
- copy_sel  in  2  copy index (addr[7:6]), captured with start.
- busy  out  1  high from the cycle after an accepted start until the return to IDLE.
- done  out  1  one-cycle pulse after a frame completes normally.
- underrun  out  1  one-cycle pulse when the frame is aborted for lack of data.
- rd_busy  in  1  MIG not ready to accept a read request.
- rd_en  out  1  read request; held until accepted.
- rd_addr  out  25  read address, {1'b0, segnum, copy_sel, word_idx[5:0]}.
- rd_data  in  256  read data; byte k = rd_data[8k+7:8k].
- rd_data_valid  in  1  one-cycle strobe per returned word, in request order.
- tx_data  out  8  output byte.
- tx_en  out  1  byte valid; stays high for the whole frame with no gaps.

## Operation
- 2-entry word buffer (FIFO). `req_cnt` counts words requested so far (0..WORDS). `outstanding` counts requested words not yet returned (0..2). The invariant outstanding + buffered ≤ 2 always holds.
- Read requester: if req_cnt < WORDS, outstanding + buffered < 2, and no request is pending, it raises rd_en with rd_addr word_idx = req_cnt. A request is accepted in a cycle with rd_en=1 and rd_busy=0. On acceptance, req_cnt and outstanding each increment by 1. While rd_busy=1, rd_en and rd_addr hold constant.
- rd_data_valid with outstanding>0: push rd_data, outstanding−1. rd_data_valid with outstanding=0 is ignored (stale data after reset or abort).
- States:
  - IDLE: start=1 captures segnum/copy_sel, clears counters, and moves to PREFILL.
  - PREFILL: waits until buffered = min(2, WORDS), then moves to SEND.
  - SEND: outputs the head word's 32 bytes, byte 0 first. After byte 31 the word is popped.
    - Last word popped → done pulse, move to IDLE.
    - Next word not buffered at the boundary → underrun pulse, tx_en low, move to DRAIN.
  - DRAIN: stop issuing requests. Any pending un-accepted rd_en is withdrawn. Once outstanding=0, flush the buffer and move to IDLE. No done pulse.
- start while busy=1 is ignored.
- A simultaneous push and pop in the same cycle is legal; the buffer count is unchanged.

## Timing
- Reset values: rd_en=0, rd_addr=0, tx_data=0, tx_en=0, busy=0, done=0, underrun=0. The state returns to IDLE and all counters and the buffer clear.
- start at edge N → busy=1 and first rd_en=1 at N+1.
- tx_en rises the cycle after the entry into SEND, with byte 0 of word 0. It is high for exactly WORDS*32 consecutive cycles.
- done=1 in the first cycle with tx_en=0 after the last byte; busy=0 in the same cycle.
- On underrun, tx_en=0 and underrun=1 in the cycle where byte 0 of the missing word would have appeared.
- Reset mid-operation takes effect immediately (async). Later rd_data_valid strobes for old requests are ignored because outstanding=0.
- All outputs are registered.

## Test plan
- WORDS=4, segnum=16'h1234, copy_sel=2, fixed read latency 5 cycles, rd_busy=0 → rd_addr 25'h123480..25'h123483, one accept each. tx_en high for 128 contiguous cycles; bytes equal the stored words LSB-first; done pulses once.
- rd_busy held high 10 cycles from the first rd_en → rd_en and rd_addr=25'h123480 stable throughout; exactly one acceptance; frame still correct.
- Latency of word 2 set to 40 cycles → underrun pulses at the byte-64 slot. tx_en low from then on; busy stays high until word 2 returns; no done; next start works.
- start pulsed again mid-SEND with a different segnum → ignored; addresses and bytes unchanged.
- RST asserted mid-SEND, then stale rd_data_valid delivered → all outputs 0 and the stale data ignored. A new start yields a clean 128-byte frame.
- WORDS=1 → a single read at word_idx 0; tx_en high for 32 cycles after the word arrives; done pulses once.

Source files
------------

// File: rtl/mig_tx_serializer.sv
// Streams one stored WORDS x 256-bit segment from DDR out as a gap-free byte frame.
// Two-word read-ahead buffer; a late word aborts the frame and drains in-flight reads.
module mig_tx_serializer #(
    parameter int WORDS = 4
) (
    input  logic         clk,
    input  logic         RST,
    input  logic         start,
    input  logic [15:0]  segnum,
    input  logic [1:0]   copy_sel,
    output logic         busy,
    output logic         done,
    output logic         underrun,
    input  logic         rd_busy,
    output logic         rd_en,
    output logic [24:0]  rd_addr,
    input  logic [255:0] rd_data,
    input  logic         rd_data_valid,
    output logic [7:0]   tx_data,
    output logic         tx_en
);
    typedef enum logic [1:0] {IDLE, PREFILL, SEND, DRAIN} state_t;

    localparam logic [6:0] WORDS_C = 7'(WORDS);
    localparam logic [1:0] FILL_C  = (WORDS >= 2) ? 2'd2 : 2'd1;

    state_t       state_q;
    logic [15:0]  seg_q;
    logic [1:0]   copy_q;
    logic [6:0]   req_cnt_q;
    logic [6:0]   pop_cnt_q;
    logic [1:0]   outst_q;
    logic [1:0]   cnt_q;
    logic         wr_ptr_q;
    logic         rd_ptr_q;
    logic [4:0]   byte_idx_q;
    logic [255:0] buf_q [2];
    logic         rd_en_q;
    logic [24:0]  rd_addr_q;
    logic [7:0]   tx_data_q;
    logic         tx_en_q;
    logic         busy_q;
    logic         done_q;
    logic         underrun_q;

    logic         accept;
    logic         push;
    logic         pop;
    logic         at_boundary;
    logic         frame_end;
    logic         starve;
    logic         send_byte;
    logic         can_req;
    logic [1:0]   outst_d;
    logic [1:0]   cnt_d;
    logic [6:0]   req_cnt_d;
    logic [2:0]   occ_d;
    logic [255:0] head_w;

    // Requests are sized against next-cycle occupancy so back-to-back issue never overfills.
    always_comb begin
        accept      = rd_en_q && !rd_busy;
        push        = rd_data_valid && (outst_q != 2'd0);
        at_boundary = (state_q == SEND) && (byte_idx_q == 5'd0);
        frame_end   = at_boundary && (pop_cnt_q == WORDS_C);
        starve      = at_boundary && (pop_cnt_q != WORDS_C) && (cnt_q == 2'd0);
        send_byte   = (state_q == SEND) && !frame_end && !starve;
        pop         = send_byte && (byte_idx_q == 5'd31);
        outst_d     = outst_q + {1'b0, accept} - {1'b0, push};
        cnt_d       = cnt_q + {1'b0, push} - {1'b0, pop};
        req_cnt_d   = req_cnt_q + {6'd0, accept};
        occ_d       = {1'b0, outst_d} + {1'b0, cnt_d};
        can_req     = (req_cnt_d < WORDS_C) && (occ_d < 3'd2);
        head_w      = buf_q[rd_ptr_q];
    end

    always_ff @(posedge clk) begin
        if (push) begin
            buf_q[wr_ptr_q] <= rd_data;
        end
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state_q    <= IDLE;
            seg_q      <= '0;
            copy_q     <= '0;
            req_cnt_q  <= '0;
            pop_cnt_q  <= '0;
            outst_q    <= '0;
            cnt_q      <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            byte_idx_q <= '0;
            rd_en_q    <= 1'b0;
            rd_addr_q  <= '0;
            tx_data_q  <= '0;
            tx_en_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            underrun_q <= 1'b0;
            outst_q    <= outst_d;
            cnt_q      <= cnt_d;
            req_cnt_q  <= req_cnt_d;
            if (push) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end

            // A pending request that has not been accepted keeps its address.
            if ((state_q == PREFILL || state_q == SEND) && !(rd_en_q && !accept)) begin
                rd_en_q <= can_req;
                if (can_req) begin
                    rd_addr_q <= {1'b0, seg_q, copy_q, req_cnt_d[5:0]};
                end
            end

            case (state_q)
                IDLE: begin
                    if (start) begin
                        seg_q      <= segnum;
                        copy_q     <= copy_sel;
                        req_cnt_q  <= '0;
                        pop_cnt_q  <= '0;
                        outst_q    <= '0;
                        cnt_q      <= '0;
                        wr_ptr_q   <= 1'b0;
                        rd_ptr_q   <= 1'b0;
                        byte_idx_q <= '0;
                        rd_en_q    <= 1'b1;
                        rd_addr_q  <= {1'b0, segnum, copy_sel, 6'd0};
                        busy_q     <= 1'b1;
                        state_q    <= PREFILL;
                    end
                end
                PREFILL: begin
                    if (cnt_q == FILL_C) begin
                        byte_idx_q <= '0;
                        state_q    <= SEND;
                    end
                end
                SEND: begin
                    if (frame_end) begin
                        tx_en_q   <= 1'b0;
                        tx_data_q <= '0;
                        done_q    <= 1'b1;
                        busy_q    <= 1'b0;
                        state_q   <= IDLE;
                    end else if (starve) begin
                        tx_en_q    <= 1'b0;
                        tx_data_q  <= '0;
                        underrun_q <= 1'b1;
                        rd_en_q    <= 1'b0;
                        state_q    <= DRAIN;
                    end else begin
                        tx_en_q    <= 1'b1;
                        tx_data_q  <= head_w[{byte_idx_q, 3'b000} +: 8];
                        byte_idx_q <= byte_idx_q + 5'd1;
                        if (pop) begin
                            pop_cnt_q <= pop_cnt_q + 7'd1;
                        end
                    end
                end
                DRAIN: begin
                    rd_en_q <= 1'b0;
                    if (outst_q == 2'd0) begin
                        cnt_q    <= '0;
                        wr_ptr_q <= 1'b0;
                        rd_ptr_q <= 1'b0;
                        busy_q   <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign underrun = underrun_q;
    assign rd_en    = rd_en_q;
    assign rd_addr  = rd_addr_q;
    assign tx_data  = tx_data_q;
    assign tx_en    = tx_en_q;

endmodule
